// File: rtl/or1200_vlx_packer.sv
// ============================================================================
// Module   : or1200_vlx_packer
// Function : Variable-length bit packer with JPEG byte stuffing, output byte
//            FIFO and acked byte-store bus port, controlled over the SPR bus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module or1200_vlx_packer #(
    parameter int          ACC_W      = 64,
    parameter int          MAX_BITS   = 16,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] ADDR_RST   = 32'h0
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          put_i,
    input  logic [$clog2(MAX_BITS+1)-1:0] put_size_i,
    input  logic [MAX_BITS-1:0]           put_dat_i,
    input  logic                          flush_i,
    input  logic                          stuff_en_i,
    input  logic                          spr_cs,
    input  logic                          spr_write,
    input  logic [1:0]                    spr_addr,
    input  logic [31:0]                   spr_dat_i,
    output logic [31:0]                   spr_dat_o,
    output logic                          stall_cpu_o,
    output logic                          store_byte_o,
    output logic [31:0]                   vlx_addr_o,
    output logic [31:0]                   dat_o,
    input  logic                          ack_i,
    output logic                          busy_o
);

    localparam int SW  = $clog2(MAX_BITS + 1);
    localparam int CW  = $clog2(ACC_W + 1);
    localparam int CW1 = CW + 1;
    localparam int FW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int NW  = FW + 1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PAD   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [7:0]        fifo_q [FIFO_DEPTH];
    logic [7:0]        fifo_d [FIFO_DEPTH];
    logic [FW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [NW-1:0]     num_q, num_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       nstored_q, nstored_d;

    logic [SW-1:0]       size_eff;
    logic [MAX_BITS-1:0] dat_masked;
    logic                accept;
    logic [7:0]          head_byte;
    logic                stuff2;
    logic [NW-1:0]       free;
    logic                ext;
    logic                pop;
    logic [2:0]          pad;
    logic                busy;
    logic                spr_wr;

    assign busy   = (cnt_q != '0) || (num_q != '0) || (state_q != ST_RUN);
    assign spr_wr = spr_cs && spr_write;

    always_comb begin
        size_eff   = (put_size_i > SW'(MAX_BITS)) ? SW'(MAX_BITS) : put_size_i;
        dat_masked = put_dat_i & ~({MAX_BITS{1'b1}} << size_eff);
        accept     = put_i && (state_q == ST_RUN) &&
                     (({1'b0, cnt_q} + CW1'(size_eff)) <= CW1'(ACC_W));

        // Oldest unextracted byte sits just below the fill level.
        head_byte  = 8'(acc_q >> (cnt_q - CW'(8)));
        stuff2     = stuff_en_i && (head_byte == 8'hFF);
        free       = NW'(FIFO_DEPTH) - num_q;
        ext        = (cnt_q >= CW'(8)) && (free >= (stuff2 ? NW'(2) : NW'(1)));
        pop        = ack_i && (num_q != '0);

        // 8 - (cnt mod 8) truncates to 0 when already byte aligned.
        pad        = (state_q == ST_PAD) ? 3'(4'd8 - {1'b0, cnt_q[2:0]}) : 3'd0;

        acc_d = acc_q;
        if (accept) begin
            acc_d = (acc_q << size_eff) | ACC_W'(dat_masked);
        end else if (pad != 3'd0) begin
            acc_d = (acc_q << pad) | ACC_W'(~(8'hFF << pad));
        end
        cnt_d = cnt_q + (accept ? CW'(size_eff) : CW'(0)) + CW'(pad)
                - (ext ? CW'(8) : CW'(0));

        fifo_d = fifo_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        if (ext) begin
            fifo_d[wr_q] = head_byte;
            if (stuff2) begin
                fifo_d[wr_q + FW'(1)] = 8'h00;
                wr_d = wr_q + FW'(2);
            end else begin
                wr_d = wr_q + FW'(1);
            end
        end
        if (pop) begin
            rd_d = rd_q + FW'(1);
        end
        num_d = num_q + (ext ? (stuff2 ? NW'(2) : NW'(1)) : NW'(0))
                - (pop ? NW'(1) : NW'(0));

        state_d = state_q;
        case (state_q)
            ST_RUN:   if (flush_i) state_d = ST_PAD;
            ST_PAD:   state_d = ST_DRAIN;
            ST_DRAIN: if ((cnt_q == '0) && (num_q == '0)) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase

        addr_d = addr_q;
        if (pop) begin
            addr_d = addr_q + 32'd1;
        end else if (spr_wr && (spr_addr == 2'b10) && !busy) begin
            addr_d = spr_dat_i;
        end

        nstored_d = nstored_q;
        if (spr_wr && (spr_addr == 2'b01)) begin
            nstored_d = 32'd0;
        end else if (pop) begin
            nstored_d = nstored_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_RUN;
            acc_q     <= '0;
            cnt_q     <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            num_q     <= '0;
            addr_q    <= ADDR_RST;
            nstored_q <= 32'd0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= 8'h00;
            end
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            num_q     <= num_d;
            addr_q    <= addr_d;
            nstored_q <= nstored_d;
            fifo_q    <= fifo_d;
        end
    end

    always_comb begin
        spr_dat_o = 32'd0;
        case (spr_addr)
            2'b00:   spr_dat_o = {16'd0, 8'(cnt_q), 5'(num_q), 1'b0, 2'(state_q)};
            2'b01:   spr_dat_o = nstored_q;
            2'b10:   spr_dat_o = addr_q;
            default: spr_dat_o = 32'd0;
        endcase
    end

    assign stall_cpu_o  = (put_i && !accept) || (state_q != ST_RUN);
    assign store_byte_o = (num_q != '0);
    assign dat_o        = {24'd0, store_byte_o ? fifo_q[rd_q] : 8'h00};
    assign vlx_addr_o   = addr_q;
    assign busy_o       = busy;

endmodule

`default_nettype wire

// File: tb/tb_or1200_vlx_packer.sv
// ============================================================================
// Module   : tb_or1200_vlx_packer
// Function : Directed, table-driven self-checking bench for or1200_vlx_packer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_or1200_vlx_packer;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        put_i = 1'b0;
    logic [4:0]  put_size_i = '0;
    logic [15:0] put_dat_i = '0;
    logic        flush_i = 1'b0;
    logic        stuff_en_i = 1'b0;
    logic        spr_cs = 1'b0;
    logic        spr_write = 1'b0;
    logic [1:0]  spr_addr = '0;
    logic [31:0] spr_dat_i = '0;
    logic [31:0] spr_dat_o;
    logic        stall_cpu_o;
    logic        store_byte_o;
    logic [31:0] vlx_addr_o;
    logic [31:0] dat_o;
    logic        ack_i = 1'b0;
    logic        busy_o;

    or1200_vlx_packer dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .put_i       (put_i),
        .put_size_i  (put_size_i),
        .put_dat_i   (put_dat_i),
        .flush_i     (flush_i),
        .stuff_en_i  (stuff_en_i),
        .spr_cs      (spr_cs),
        .spr_write   (spr_write),
        .spr_addr    (spr_addr),
        .spr_dat_i   (spr_dat_i),
        .spr_dat_o   (spr_dat_o),
        .stall_cpu_o (stall_cpu_o),
        .store_byte_o(store_byte_o),
        .vlx_addr_o  (vlx_addr_o),
        .dat_o       (dat_o),
        .ack_i       (ack_i),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [63:0] got [$];   // {store address, dat_o} of each acked store

    always @(negedge clk) begin
        if (!rst_i && store_byte_o && ack_i) got.push_back({vlx_addr_o, dat_o});
    end

    typedef struct {
        logic [4:0]  size;
        logic [15:0] dat;
        logic        stuff;
        logic        flush;
        int          n;
        logic [31:0] bytes;   // expected stores, first byte in [31:24]
    } vec_t;

    vec_t vecs [12];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic spr_rd(input logic [1:0] a, output logic [31:0] d);
        spr_addr = a;
        #2;
        d = spr_dat_o;
    endtask

    task automatic spr_wr(input logic [1:0] a, input logic [31:0] d);
        spr_cs = 1'b1; spr_write = 1'b1; spr_addr = a; spr_dat_i = d;
        step();
        spr_cs = 1'b0; spr_write = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 300; i++) begin
            if (!busy_o) break;
            step();
        end
        chk(nm, {31'd0, busy_o}, 32'd0);
    endtask

    task automatic put1(input logic [4:0] sz, input logic [15:0] d, input logic fl);
        put_i = 1'b1; put_size_i = sz; put_dat_i = d; flush_i = fl;
        step();
        put_i = 1'b0; flush_i = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] exp_addr;
        logic [31:0] bt;
        int          n;

        vecs[0]  = '{5'd8,  16'h00A5, 1'b0, 1'b0, 1, 32'hA5000000};
        vecs[1]  = '{5'd8,  16'h00FF, 1'b1, 1'b0, 2, 32'hFF000000};
        vecs[2]  = '{5'd8,  16'h00FF, 1'b0, 1'b0, 1, 32'hFF000000};
        vecs[3]  = '{5'd5,  16'h0017, 1'b0, 1'b1, 1, 32'hBF000000};
        vecs[4]  = '{5'd5,  16'h001F, 1'b1, 1'b1, 2, 32'hFF000000};
        vecs[5]  = '{5'd16, 16'h1234, 1'b0, 1'b0, 2, 32'h12340000};
        vecs[6]  = '{5'd12, 16'h0ABC, 1'b0, 1'b1, 2, 32'hABCF0000};
        vecs[7]  = '{5'd20, 16'h8001, 1'b0, 1'b0, 2, 32'h80010000};
        vecs[8]  = '{5'd4,  16'hFFF3, 1'b1, 1'b1, 1, 32'h3F000000};
        vecs[9]  = '{5'd0,  16'hFFFF, 1'b0, 1'b1, 0, 32'h00000000};
        vecs[10] = '{5'd16, 16'hFF00, 1'b1, 1'b0, 3, 32'hFF000000};
        vecs[11] = '{5'd31, 16'hFFFF, 1'b1, 1'b0, 4, 32'hFF00FF00};

        // Reset state
        step(); step();
        chk("rst store", {31'd0, store_byte_o}, 32'd0);
        chk("rst stall", {31'd0, stall_cpu_o}, 32'd0);
        chk("rst busy",  {31'd0, busy_o}, 32'd0);
        chk("rst dat",   dat_o, 32'd0);
        chk("rst addr",  vlx_addr_o, 32'd0);
        rst_i = 1'b0;
        step();

        // Single-put vectors, ack tied high
        ack_i = 1'b1;
        exp_addr = 32'd0;
        for (int i = 0; i < 12; i++) begin
            got.delete();
            stuff_en_i = vecs[i].stuff;
            put1(vecs[i].size, vecs[i].dat, vecs[i].flush);
            wait_idle($sformatf("v%0d idle", i));
            chk($sformatf("v%0d nbytes", i), got.size(), vecs[i].n);
            bt = vecs[i].bytes;
            for (int k = 0; k < vecs[i].n && k < got.size(); k++) begin
                chk($sformatf("v%0d byte%0d", i, k), got[k][31:0], {24'd0, bt[31-8*k -: 8]});
                chk($sformatf("v%0d addr%0d", i, k), got[k][63:32], exp_addr + k);
            end
            exp_addr = exp_addr + vecs[i].n;
        end
        spr_rd(2'b01, rd); chk("stored count", rd, 32'd21);
        spr_rd(2'b10, rd); chk("addr after table", rd, 32'd21);
        step();

        // 101 then 11 then flush: one 0xBF, busy until the ack lands
        ack_i = 1'b0; stuff_en_i = 1'b0; got.delete();
        put1(5'd3, 16'h0005, 1'b0);
        put1(5'd2, 16'h0003, 1'b0);
        put1(5'd0, 16'h0000, 1'b1);
        for (int k = 0; k < 20; k++) begin
            if (store_byte_o) break;
            step();
        end
        chk("flush store", {31'd0, store_byte_o}, 32'd1);
        chk("flush dat", dat_o, 32'h000000BF);
        step(); step();
        chk("flush busy held", {31'd0, busy_o}, 32'd1);
        spr_rd(2'b00, rd); chk("flush fsm not run", {31'd0, rd[1:0] != 2'b00}, 32'd1);
        ack_i = 1'b1;
        step();
        ack_i = 1'b0;
        wait_idle("flush idle");
        spr_rd(2'b00, rd); chk("flush fsm run", {30'd0, rd[1:0]}, 32'd0);
        chk("flush one store", got.size(), 1);
        if (got.size() > 0) chk("flush store addr", got[0][63:32], exp_addr);
        exp_addr = exp_addr + 1;

        // FIFO full, accumulator fills to 64, then stall until ack frees room
        got.delete();
        for (int i = 0; i < 6; i++) begin
            put_i = 1'b1; put_size_i = 5'd16;
            put_dat_i = {8'(2*i+1), 8'(2*i+2)};
            #2;
            chk($sformatf("fill stall w%0d", i), {31'd0, stall_cpu_o}, 32'd0);
            step();
        end
        put_dat_i = 16'h0D0E;
        #2;
        chk("full stall", {31'd0, stall_cpu_o}, 32'd1);
        spr_rd(2'b00, rd); chk("full status", rd, 32'h00004020);
        step();
        chk("full stall held", {31'd0, stall_cpu_o}, 32'd1);
        ack_i = 1'b1;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            if (!stall_cpu_o) break;
            n++;
            step();
        end
        chk("stall cycles", n, 3);
        step();
        put_i = 1'b0;
        wait_idle("full idle");
        chk("full nbytes", got.size(), 14);
        for (int k = 0; k < 14 && k < got.size(); k++) begin
            chk($sformatf("full byte%0d", k), got[k][31:0], 32'(k + 1));
            chk($sformatf("full addr%0d", k), got[k][63:32], exp_addr + k);
        end

        // SPR address write: honoured when idle, ignored when busy
        got.delete();
        spr_wr(2'b10, 32'h0000_1000);
        spr_rd(2'b10, rd); chk("spr addr rd", rd, 32'h0000_1000);
        put1(5'd8, 16'h00A5, 1'b0);
        wait_idle("spr idle");
        chk("spr nbytes", got.size(), 1);
        if (got.size() > 0) chk("spr store addr", got[0][63:32], 32'h0000_1000);
        ack_i = 1'b0;
        put1(5'd8, 16'h005A, 1'b0);
        spr_wr(2'b10, 32'h0000_2000);
        spr_rd(2'b10, rd); chk("spr busy write ignored", rd, 32'h0000_1001);
        ack_i = 1'b1;
        wait_idle("spr idle2");
        spr_wr(2'b01, 32'h0);
        spr_rd(2'b01, rd); chk("count cleared", rd, 32'd0);
        spr_rd(2'b11, rd); chk("spr reg3", rd, 32'd0);

        // Reset mid-transfer
        ack_i = 1'b0;
        put1(5'd12, 16'h0ABC, 1'b0);
        put1(5'd8, 16'h005A, 1'b0);
        spr_rd(2'b00, rd); chk("pre-rst cnt", {24'd0, rd[15:8]}, 32'd12);
        chk("pre-rst store", {31'd0, store_byte_o}, 32'd1);
        rst_i = 1'b1;
        step();
        chk("rst2 store", {31'd0, store_byte_o}, 32'd0);
        spr_rd(2'b00, rd); chk("rst2 cnt", {24'd0, rd[15:8]}, 32'd0);
        chk("rst2 addr", vlx_addr_o, 32'd0);
        chk("rst2 stall", {31'd0, stall_cpu_o}, 32'd0);
        chk("rst2 busy", {31'd0, busy_o}, 32'd0);
        rst_i = 1'b0;
        ack_i = 1'b1;
        step(); step();
        chk("idle ack ignored", vlx_addr_o, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
